// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 configuration path: FSM states,
// table-word field positions and helpers that build bus words from a table entry.
package ov5640_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        FETCH,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        CHECK,
        GAP,
        DELAY,
        NEXT,
        FIN
    } cfg_state_t;

    localparam int ID_MSB   = 31;
    localparam int DIR_BIT  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [7:0] DLY_ID    = 8'h00;
    localparam logic [7:0] OV5640_ID = 8'h78;

    function automatic logic [31:0] wr_word(input logic [31:0] w);
        logic [31:0] r;
        r          = w;
        r[DIR_BIT] = 1'b0;
        return r;
    endfunction

    // Read-back word: same device and register, direction bit set, data field cleared.
    function automatic logic [31:0] rd_word(input logic [31:0] w);
        return {w[ID_MSB:DIR_BIT+1], 1'b1, w[ADDR_MSB:ADDR_LSB], 8'h00};
    endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// OV5640 power-up register table, indexed by the sequencer's rom_idx.
// Indices beyond the populated entries read as zero-length delay entries.
module ov5640_cfg_rom
    import ov5640_pkg::*;
(
    input  logic [7:0]  rom_idx,
    output logic [31:0] rom_data
);

    always_comb begin
        rom_data = {DLY_ID, 24'h000000};
        case (rom_idx)
            8'd0:  rom_data = {OV5640_ID, 24'h3008_82};
            8'd1:  rom_data = {DLY_ID,    24'h0000_02};
            8'd2:  rom_data = {OV5640_ID, 24'h3008_42};
            8'd3:  rom_data = {OV5640_ID, 24'h3103_03};
            8'd4:  rom_data = {OV5640_ID, 24'h3017_ff};
            8'd5:  rom_data = {OV5640_ID, 24'h3018_ff};
            8'd6:  rom_data = {OV5640_ID, 24'h3034_1a};
            8'd7:  rom_data = {OV5640_ID, 24'h3037_13};
            8'd8:  rom_data = {OV5640_ID, 24'h3108_01};
            8'd9:  rom_data = {OV5640_ID, 24'h3630_36};
            8'd10: rom_data = {OV5640_ID, 24'h3631_0e};
            8'd11: rom_data = {OV5640_ID, 24'h3632_e2};
            8'd12: rom_data = {OV5640_ID, 24'h3633_12};
            8'd13: rom_data = {OV5640_ID, 24'h3621_e0};
            8'd14: rom_data = {OV5640_ID, 24'h3704_a0};
            8'd15: rom_data = {OV5640_ID, 24'h3703_5a};
            8'd16: rom_data = {OV5640_ID, 24'h3715_78};
            8'd17: rom_data = {OV5640_ID, 24'h3717_01};
            8'd18: rom_data = {OV5640_ID, 24'h370b_60};
            8'd19: rom_data = {OV5640_ID, 24'h3705_1a};
            8'd20: rom_data = {OV5640_ID, 24'h3008_02};
            default: rom_data = {DLY_ID, 24'h000000};
        endcase
    end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Walks the OV5640 register table and drives one SCCB/IIC master transaction per
// entry, with in-table delays, optional write read-back verify, retries and error counting.
module ov5640_cfg_sequencer
    import ov5640_pkg::*;
#(
    parameter int          REG_NUM   = 252,
    parameter logic [19:0] PWR_DLY   = 20'd1_000_000,
    parameter logic [15:0] DLY_UNIT  = 16'd50_000,
    parameter logic [7:0]  GAP_CYC   = 8'd100,
    parameter logic [15:0] TO_CYC    = 16'd4096,
    parameter bit          VERIFY    = 1'b1,
    parameter int          MAX_RETRY = 2
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        cfg_en,
    output logic [7:0]  rom_idx,
    input  logic [31:0] rom_data,
    output logic [31:0] iic_wdata,
    output logic        iic_start,
    input  logic        iic_busy,
    input  logic [7:0]  iic_rdata,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_cnt
);

    cfg_state_t  state, state_nxt, gap_ret, gap_ret_nxt;
    logic [31:0] cnt, cnt_nxt, word, word_nxt, wdata_nxt, dly_target;
    logic [7:0]  idx_nxt, retry, retry_nxt, err_cnt_nxt;
    logic        rd_phase, rd_phase_nxt, done_nxt, err_nxt, err_evt;

    // True on the last cycle of an n-cycle wait; a zero-length wait ends at once.
    function automatic logic hit(input logic [31:0] c, input logic [31:0] n);
        return (n == 32'd0) || (c == n - 32'd1);
    endfunction

    assign dly_target = 32'(word[15:0]) * 32'(DLY_UNIT);
    assign cfg_busy   = (state != IDLE) && (state != FIN);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt       <= '0;
            word      <= '0;
            iic_wdata <= '0;
            rom_idx   <= '0;
            retry     <= '0;
            rd_phase  <= 1'b0;
            gap_ret   <= NEXT;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            word      <= word_nxt;
            iic_wdata <= wdata_nxt;
            rom_idx   <= idx_nxt;
            retry     <= retry_nxt;
            rd_phase  <= rd_phase_nxt;
            gap_ret   <= gap_ret_nxt;
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    // The start pulse is held back while the master is still busy, so a stuck
    // master from a timed-out entry cannot receive an overlapping start.
    always_comb begin
        state_nxt    = state;
        gap_ret_nxt  = gap_ret;
        word_nxt     = word;
        wdata_nxt    = iic_wdata;
        idx_nxt      = rom_idx;
        retry_nxt    = retry;
        rd_phase_nxt = rd_phase;
        done_nxt     = cfg_done;
        err_nxt      = cfg_err;
        err_cnt_nxt  = err_cnt;
        err_evt      = 1'b0;
        iic_start    = 1'b0;

        unique case (state)
            IDLE, FIN: begin
                if (cfg_en) begin
                    state_nxt    = PWR_WAIT;
                    idx_nxt      = '0;
                    done_nxt     = 1'b0;
                    err_nxt      = 1'b0;
                    err_cnt_nxt  = '0;
                    retry_nxt    = '0;
                    rd_phase_nxt = 1'b0;
                end
            end
            PWR_WAIT: if (hit(cnt, 32'(PWR_DLY))) state_nxt = FETCH;
            FETCH: begin
                word_nxt = rom_data;
                if (rom_data[ID_MSB -: 8] == DLY_ID) begin
                    state_nxt = DELAY;
                end else begin
                    wdata_nxt = wr_word(rom_data);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!iic_busy) begin
                    iic_start = 1'b1;
                    state_nxt = WAIT_HI;
                end else if (hit(cnt, 32'(TO_CYC))) begin
                    err_evt   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            WAIT_HI: begin
                if (iic_busy) begin
                    state_nxt = WAIT_LO;
                end else if (hit(cnt, 32'd4)) begin
                    err_evt   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            WAIT_LO: begin
                if (!iic_busy) begin
                    state_nxt = CHECK;
                end else if (hit(cnt, 32'(TO_CYC))) begin
                    err_evt   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            CHECK: begin
                if (!rd_phase) begin
                    state_nxt = GAP;
                    if (VERIFY) begin
                        wdata_nxt    = rd_word(word);
                        rd_phase_nxt = 1'b1;
                        gap_ret_nxt  = ISSUE;
                    end else begin
                        gap_ret_nxt  = NEXT;
                    end
                end else if (iic_rdata == word[DATA_MSB:DATA_LSB]) begin
                    state_nxt   = GAP;
                    gap_ret_nxt = NEXT;
                end else if (int'(retry) < MAX_RETRY) begin
                    retry_nxt    = retry + 8'd1;
                    wdata_nxt    = wr_word(word);
                    rd_phase_nxt = 1'b0;
                    gap_ret_nxt  = ISSUE;
                    state_nxt    = GAP;
                end else begin
                    err_evt   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            GAP:   if (hit(cnt, 32'(GAP_CYC))) state_nxt = gap_ret;
            DELAY: if (hit(cnt, dly_target)) state_nxt = NEXT;
            NEXT: begin
                rd_phase_nxt = 1'b0;
                if (rom_idx == 8'(REG_NUM - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = rom_idx + 8'd1;
                    retry_nxt = '0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (err_evt) begin
            err_nxt     = 1'b1;
            err_cnt_nxt = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
            retry_nxt   = '0;
        end

        cnt_nxt = (state_nxt != state) ? 32'd0 : cnt + 32'd1;
    end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Scoreboard bench: two sequencers (verify off / on) each driven by a small IIC master
// model; expected bus words are queued by the stimulus and popped at every start pulse.
module tb_ov5640_cfg_sequencer;

    localparam int BLEN     = 20;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    logic             sclk    = 1'b0;
    logic             s_rst_n = 1'b0;
    logic [1:0]       cfg_en, iic_start, iic_busy, cfg_busy, cfg_done, cfg_err;
    logic [1:0][7:0]  rom_idx, iic_rdata, err_cnt;
    logic [1:0][31:0] rom_data, iic_wdata;
    logic [7:0]       probe_idx;
    logic [31:0]      probe_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mode [2];
    bit          corrupt [2];
    int          m_rem [2];
    logic [7:0]  m_last [2];
    logic [31:0] expq [2][$];
    int          n_start [2];
    int          last_start [2];
    int          prev_start [2];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [31:0] tbl(input int k, input logic [7:0] idx);
        if (k == 0) begin
            case (idx)
                8'd0: return 32'h7830_0882;
                8'd1: return 32'h0000_0002;
                8'd2: return 32'h7831_0303;
                default: return 32'h0;
            endcase
        end
        case (idx)
            8'd0: return 32'h7830_0882;
            8'd1: return 32'h7831_0303;
            8'd2: return 32'h7830_0842;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        rom_data[0] = tbl(0, rom_idx[0]);
        rom_data[1] = tbl(1, rom_idx[1]);
    end

    ov5640_cfg_sequencer #(
        .REG_NUM(3), .PWR_DLY(20'd20), .DLY_UNIT(16'd10), .GAP_CYC(8'd5),
        .TO_CYC(16'd40), .VERIFY(1'b0), .MAX_RETRY(2)
    ) u_dut0 (
        .sclk(sclk), .s_rst_n(s_rst_n), .cfg_en(cfg_en[0]), .rom_idx(rom_idx[0]),
        .rom_data(rom_data[0]), .iic_wdata(iic_wdata[0]), .iic_start(iic_start[0]),
        .iic_busy(iic_busy[0]), .iic_rdata(iic_rdata[0]), .cfg_busy(cfg_busy[0]),
        .cfg_done(cfg_done[0]), .cfg_err(cfg_err[0]), .err_cnt(err_cnt[0])
    );

    ov5640_cfg_sequencer #(
        .REG_NUM(3), .PWR_DLY(20'd20), .DLY_UNIT(16'd10), .GAP_CYC(8'd5),
        .TO_CYC(16'd40), .VERIFY(1'b1), .MAX_RETRY(2)
    ) u_dut1 (
        .sclk(sclk), .s_rst_n(s_rst_n), .cfg_en(cfg_en[1]), .rom_idx(rom_idx[1]),
        .rom_data(rom_data[1]), .iic_wdata(iic_wdata[1]), .iic_start(iic_start[1]),
        .iic_busy(iic_busy[1]), .iic_rdata(iic_rdata[1]), .cfg_busy(cfg_busy[1]),
        .cfg_done(cfg_done[1]), .cfg_err(cfg_err[1]), .err_cnt(err_cnt[1])
    );

    ov5640_cfg_rom u_rom (.rom_idx(probe_idx), .rom_data(probe_data));

    // Master model: busy for BLEN cycles per start; remembers the last written byte
    // and returns it on read, or 8'hFF for register 0x3103 when corrupt is set.
    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                iic_busy[k]  <= 1'b0;
                iic_rdata[k] <= 8'h00;
                m_rem[k]     <= 0;
                m_last[k]    <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (iic_start[k] && !iic_busy[k] && mode[k] != M_NEVER) begin
                    iic_busy[k] <= 1'b1;
                    m_rem[k]    <= BLEN - 1;
                    if (!iic_wdata[k][24]) m_last[k] <= iic_wdata[k][7:0];
                    else iic_rdata[k] <= (corrupt[k] && iic_wdata[k][23:8] == 16'h3103)
                                         ? 8'hFF : m_last[k];
                end else if (iic_busy[k]) begin
                    if (m_rem[k] != 0)          m_rem[k]    <= m_rem[k] - 1;
                    else if (mode[k] != M_STUCK) iic_busy[k] <= 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (s_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (iic_start[k]) begin
                    n_start[k]++;
                    prev_start[k] = last_start[k];
                    last_start[k] = cyc;
                    check_output($sformatf("start_idle_bus%0d", k), 64'(iic_busy[k]), 64'd0);
                    if (expq[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_start%0d: got 0x%0h, expected no start",
                                 k, iic_wdata[k]);
                    end else begin
                        check_output($sformatf("wdata%0d", k), 64'(iic_wdata[k]),
                                     64'(expq[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic expect_words(input int k, input logic [31:0] w [$]);
        foreach (w[i]) expq[k].push_back(w[i]);
    endtask

    task automatic apply_stimulus(input int k, output int at);
        @(negedge sclk);
        cfg_en[k] = 1'b1;
        at        = cyc;
        @(negedge sclk);
        cfg_en[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (!(cfg_done[k] && !cfg_busy[k]) && n < budget) begin
            @(negedge sclk);
            n++;
        end
        check_output($sformatf("done_in_time%0d", k), 64'(n < budget), 64'd1);
    endtask

    task automatic wait_err(input int k, input int budget);
        int n = 0;
        while (err_cnt[k] == 8'd0 && n < budget) begin
            @(negedge sclk);
            n++;
        end
        check_output($sformatf("err_in_time%0d", k), 64'(n < budget), 64'd1);
    endtask

    task automatic wait_start(input int k, input int prev, input int budget);
        int n = 0;
        while (n_start[k] <= prev && n < budget) begin
            @(negedge sclk);
            n++;
        end
        check_output($sformatf("start_in_time%0d", k), 64'(n < budget), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("%s_ctl%0d", name, k),
                         64'({rom_idx[k], err_cnt[k], iic_start[k], cfg_busy[k],
                              cfg_done[k], cfg_err[k]}), 64'd0);
            check_output($sformatf("%s_wdata%0d", name, k), 64'(iic_wdata[k]), 64'd0);
        end
    endtask

    task automatic check_end(input int k, input string name, input logic err,
                             input logic [7:0] ecnt, input int starts, input int s0);
        check_output({name, "_done"}, 64'(cfg_done[k]), 64'd1);
        check_output({name, "_err"}, 64'(cfg_err[k]), 64'(err));
        check_output({name, "_err_cnt"}, 64'(err_cnt[k]), 64'(ecnt));
        check_output({name, "_last_idx"}, 64'(rom_idx[k]), 64'd2);
        check_output({name, "_starts"}, 64'(n_start[k] - s0), 64'(starts));
        check_output({name, "_drain"}, 64'(expq[k].size()), 64'd0);
    endtask

    initial begin
        int t, t2, s0;
        cfg_en     = 2'b00;
        mode[0]    = M_NORMAL;
        mode[1]    = M_NORMAL;
        corrupt[0] = 1'b0;
        corrupt[1] = 1'b0;
        n_start[0] = 0;
        n_start[1] = 0;
        probe_idx  = 8'd0;

        repeat (3) @(negedge sclk);
        check_reset_outputs("in_reset");
        s_rst_n = 1'b1;
        @(negedge sclk);
        check_reset_outputs("after_reset");

        check_output("rom_entry0", 64'(probe_data), 64'h7830_0882);
        probe_idx = 8'd1;
        #1 check_output("rom_entry1", 64'(probe_data), 64'h0000_0002);
        probe_idx = 8'd250;
        #1 check_output("rom_unused", 64'(probe_data), 64'h0);

        $display("[TB] write-only table with delay entry");
        s0 = n_start[0];
        expect_words(0, '{32'h7830_0882, 32'h7831_0303});
        apply_stimulus(0, t);
        check_output("busy_in_pwr_wait", 64'(cfg_busy[0]), 64'd1);
        wait_done(0, 1000);
        check_output("start_spacing", 64'(last_start[0] - prev_start[0]), 64'd52);
        check_end(0, "plain", 1'b0, 8'd0, 2, s0);

        $display("[TB] verify with matching read-back");
        s0 = n_start[1];
        expect_words(1, '{32'h7830_0882, 32'h7930_0800, 32'h7831_0303, 32'h7931_0300,
                          32'h7830_0842, 32'h7930_0800});
        apply_stimulus(1, t);
        wait_done(1, 2000);
        check_end(1, "verify_ok", 1'b0, 8'd0, 6, s0);

        $display("[TB] verify mismatch on 0x3103");
        corrupt[1] = 1'b1;
        s0 = n_start[1];
        expect_words(1, '{32'h7830_0882, 32'h7930_0800,
                          32'h7831_0303, 32'h7931_0300, 32'h7831_0303, 32'h7931_0300,
                          32'h7831_0303, 32'h7931_0300,
                          32'h7830_0842, 32'h7930_0800});
        apply_stimulus(1, t);
        wait_done(1, 3000);
        check_end(1, "verify_bad", 1'b1, 8'd1, 10, s0);
        corrupt[1] = 1'b0;

        $display("[TB] master never raises busy");
        mode[1] = M_NEVER;
        s0 = n_start[1];
        expect_words(1, '{32'h7830_0882, 32'h7831_0303, 32'h7830_0842});
        apply_stimulus(1, t);
        wait_err(1, 200);
        check_output("no_busy_err_delay", 64'(cyc - last_start[1]), 64'd5);
        wait_done(1, 500);
        check_end(1, "no_busy", 1'b1, 8'd3, 3, s0);
        mode[1] = M_NORMAL;

        $display("[TB] busy stuck high");
        mode[0] = M_STUCK;
        s0 = n_start[0];
        expect_words(0, '{32'h7830_0882, 32'h7831_0303});
        apply_stimulus(0, t);
        wait_err(0, 300);
        check_output("timeout_delay", 64'(cyc - last_start[0]), 64'd42);
        mode[0] = M_NORMAL;
        wait_done(0, 1000);
        check_end(0, "stuck", 1'b1, 8'd1, 2, s0);

        $display("[TB] ignored cfg_en, reset in WAIT_LO, restart");
        s0 = n_start[0];
        expect_words(0, '{32'h7830_0882});
        apply_stimulus(0, t);
        repeat (8) @(negedge sclk);
        apply_stimulus(0, t2);
        wait_start(0, s0, 200);
        check_output("first_start_latency", 64'(last_start[0] - t), 64'd22);
        repeat (5) @(negedge sclk);
        check_output("busy_before_reset", 64'(cfg_busy[0]), 64'd1);
        s_rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        check_output("reset_drain", 64'(expq[0].size()), 64'd0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        s0 = n_start[0];
        expect_words(0, '{32'h7830_0882, 32'h7831_0303});
        apply_stimulus(0, t);
        check_output("restart_idx", 64'(rom_idx[0]), 64'd0);
        wait_done(0, 1000);
        check_end(0, "restart", 1'b0, 8'd0, 2, s0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
